present_test_sequencer: RTL and testbench



---
 rtl/present_test_sequencer_pkg.sv | 34 +++
 rtl/present_seq_timer.sv | 34 +++
 rtl/present_test_sequencer.sv | 150 +++++++++++++++
 tb/tb_present_test_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/present_test_sequencer_pkg.sv
// Shared definitions for the PRESENT test sequencer.
// Contents: default interval constants, state encodings and state type,
// and the counter width helper (enough bits to hold the value N itself).
package present_test_sequencer_pkg;

  localparam int SETTLE_DEF     = 2;
  localparam int LOAD_BLANK_DEF = 2;
  localparam int TIMEOUT_DEF    = 40;

  // Fixed encodings keep the state values stable for anyone probing the
  // state register against older netlists.
  localparam logic [2:0] ENC_IDLE   = 3'd0;
  localparam logic [2:0] ENC_SETUP  = 3'd1;
  localparam logic [2:0] ENC_LOAD   = 3'd2;
  localparam logic [2:0] ENC_BLANK  = 3'd3;
  localparam logic [2:0] ENC_WAIT   = 3'd4;
  localparam logic [2:0] ENC_NEXT   = 3'd5;
  localparam logic [2:0] ENC_FINISH = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE   = ENC_IDLE,
    ST_SETUP  = ENC_SETUP,
    ST_LOAD   = ENC_LOAD,
    ST_BLANK  = ENC_BLANK,
    ST_WAIT   = ENC_WAIT,
    ST_NEXT   = ENC_NEXT,
    ST_FINISH = ENC_FINISH
  } seq_state_e;

  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/present_seq_timer.sv
// Loadable down-counter used for the settle, blanking and timeout intervals.
// Ports:
//   clk     - clock, posedge
//   rst     - synchronous active-high reset (count cleared)
//   load    - load value into the counter this edge
//   value   - count to load; interval length is value+1 cycles
//   expired - terminal count, high while the counter is zero
module present_seq_timer
  import present_test_sequencer_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             expired
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/present_test_sequencer.sv
// Autonomous sweep controller for the PRESENT hardware test apparatus.
// Walks every test-case address, pulses load, waits a bounded time for the
// apparatus valid and tallies pass/fail results.
// Build option: PRESENT_SEQ_STOP_ON_FAIL_EN ends the sweep at the first timeout.
// Ports:
//   sig_mstr_clk       - master clock, posedge
//   sig_in_rst         - synchronous active-high reset
//   sig_in_start       - start a sweep (honoured only in IDLE or FINISH)
//   sig_in_valid       - apparatus pass indication
//   vec_out_sel_addr   - test-case address to apparatus
//   sig_out_load       - one-cycle load pulse
//   sig_out_busy       - sweep in progress
//   sig_out_done       - sweep finished, held until next start or reset
//   sig_out_all_pass   - no failures in the finished sweep
//   vec_out_pass_cnt   - number of passing cases
//   vec_out_fail_cnt   - number of timed-out cases
//   vec_out_first_fail - address of the first failing case, 0 if none
// SETTLE, LOAD_BLANK and TIMEOUT must each be at least 1.
module present_test_sequencer
  import present_test_sequencer_pkg::*;
#(
  parameter int TEST_CASE_SIZE = 32,
  parameter int SETTLE         = SETTLE_DEF,
  parameter int LOAD_BLANK     = LOAD_BLANK_DEF,
  parameter int TIMEOUT        = TIMEOUT_DEF,
  parameter int AW             = $clog2(TEST_CASE_SIZE),
  parameter int CW             = cnt_width(TEST_CASE_SIZE)
) (
  input  logic          sig_mstr_clk,
  input  logic          sig_in_rst,
  input  logic          sig_in_start,
  input  logic          sig_in_valid,
  output logic [AW-1:0] vec_out_sel_addr,
  output logic          sig_out_load,
  output logic          sig_out_busy,
  output logic          sig_out_done,
  output logic          sig_out_all_pass,
  output logic [CW-1:0] vec_out_pass_cnt,
  output logic [CW-1:0] vec_out_fail_cnt,
  output logic [AW-1:0] vec_out_first_fail
);

  localparam int TW = $clog2(SETTLE + LOAD_BLANK + TIMEOUT + 1);

  seq_state_e    state, state_n;
  logic [AW-1:0] addr_n, first_fail_n;
  logic [CW-1:0] pass_n, fail_n;
  logic          tmr_load, tmr_expired;
  logic [TW-1:0] tmr_value;

  present_seq_timer #(.WIDTH(TW)) u_timer (
    .clk     (sig_mstr_clk),
    .rst     (sig_in_rst),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (tmr_expired)
  );

  // The timer is reloaded with (interval-1) on entry to each timed state,
  // so the state is left in the cycle where the timer reads zero.
  always_comb begin
    state_n      = state;
    addr_n       = vec_out_sel_addr;
    pass_n       = vec_out_pass_cnt;
    fail_n       = vec_out_fail_cnt;
    first_fail_n = vec_out_first_fail;
    tmr_load     = 1'b0;
    tmr_value    = '0;
    unique case (state)
      ST_IDLE, ST_FINISH: begin
        if (sig_in_start) begin
          state_n      = ST_SETUP;
          addr_n       = '0;
          pass_n       = '0;
          fail_n       = '0;
          first_fail_n = '0;
          tmr_load     = 1'b1;
          tmr_value    = TW'(SETTLE - 1);
        end
      end
      ST_SETUP: begin
        if (tmr_expired) state_n = ST_LOAD;
      end
      ST_LOAD: begin
        state_n   = ST_BLANK;
        tmr_load  = 1'b1;
        tmr_value = TW'(LOAD_BLANK - 1);
      end
      ST_BLANK: begin
        if (tmr_expired) begin
          state_n   = ST_WAIT;
          tmr_load  = 1'b1;
          tmr_value = TW'(TIMEOUT - 1);
        end
      end
      ST_WAIT: begin
        // Valid takes priority, so valid on the last timeout cycle passes.
        if (sig_in_valid) begin
          pass_n  = vec_out_pass_cnt + CW'(1);
          state_n = ST_NEXT;
        end else if (tmr_expired) begin
          fail_n = vec_out_fail_cnt + CW'(1);
          if (vec_out_fail_cnt == '0) first_fail_n = vec_out_sel_addr;
`ifdef PRESENT_SEQ_STOP_ON_FAIL_EN
          state_n = ST_FINISH;
`else
          state_n = ST_NEXT;
`endif
        end
      end
      ST_NEXT: begin
        if (vec_out_sel_addr == AW'(TEST_CASE_SIZE - 1)) begin
          state_n = ST_FINISH;
        end else begin
          addr_n    = vec_out_sel_addr + AW'(1);
          state_n   = ST_SETUP;
          tmr_load  = 1'b1;
          tmr_value = TW'(SETTLE - 1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Status flags are decoded from the next state so every output is a flop.
  always_ff @(posedge sig_mstr_clk) begin
    if (sig_in_rst) begin
      state              <= ST_IDLE;
      vec_out_sel_addr   <= '0;
      vec_out_pass_cnt   <= '0;
      vec_out_fail_cnt   <= '0;
      vec_out_first_fail <= '0;
      sig_out_load       <= 1'b0;
      sig_out_busy       <= 1'b0;
      sig_out_done       <= 1'b0;
      sig_out_all_pass   <= 1'b0;
    end else begin
      state              <= state_n;
      vec_out_sel_addr   <= addr_n;
      vec_out_pass_cnt   <= pass_n;
      vec_out_fail_cnt   <= fail_n;
      vec_out_first_fail <= first_fail_n;
      sig_out_load       <= (state_n == ST_LOAD);
      sig_out_busy       <= (state_n != ST_IDLE) && (state_n != ST_FINISH);
      sig_out_done       <= (state_n == ST_FINISH);
      sig_out_all_pass   <= (state_n == ST_FINISH) && (fail_n == '0);
    end
  end

endmodule

// File: tb/tb_present_test_sequencer.sv
// Self-checking bench for present_test_sequencer.
// A stub apparatus pulses valid a programmable number of cycles after each
// load; a reference model derives the expected tallies from the stub delays.
module tb_present_test_sequencer;

  localparam int N   = 32;
  localparam int ST  = 2;
  localparam int LB  = 2;
  localparam int T   = 40;
  localparam int AW  = $clog2(N);
  localparam int CW  = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          valid = 1'b0;
  logic [AW-1:0] addr;
  logic          load, busy, done, all_pass;
  logic [CW-1:0] pass_cnt, fail_cnt;
  logic [AW-1:0] first_fail;

  int n_checks = 0;
  int n_errors = 0;
  int dly[N];  // valid pulse delay after load per address; <=0 means never

  present_test_sequencer #(
    .TEST_CASE_SIZE (N),
    .SETTLE         (ST),
    .LOAD_BLANK     (LB),
    .TIMEOUT        (T)
  ) dut (
    .sig_mstr_clk       (clk),
    .sig_in_rst         (rst),
    .sig_in_start       (start),
    .sig_in_valid       (valid),
    .vec_out_sel_addr   (addr),
    .sig_out_load       (load),
    .sig_out_busy       (busy),
    .sig_out_done       (done),
    .sig_out_all_pass   (all_pass),
    .vec_out_pass_cnt   (pass_cnt),
    .vec_out_fail_cnt   (fail_cnt),
    .vec_out_first_fail (first_fail)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp_v);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ":addr"}, int'(addr), 0);
    check({tag, ":load"}, int'(load), 0);
    check({tag, ":busy"}, int'(busy), 0);
    check({tag, ":done"}, int'(done), 0);
    check({tag, ":all_pass"}, int'(all_pass), 0);
    check({tag, ":pass_cnt"}, int'(pass_cnt), 0);
    check({tag, ":fail_cnt"}, int'(fail_cnt), 0);
    check({tag, ":first_fail"}, int'(first_fail), 0);
  endtask

  // A case passes when its valid pulse lands inside the wait window, which
  // opens after the blanking cycles and lasts T cycles.
  function automatic bit case_passes(input int d);
    return (d >= LB + 1) && (d <= LB + T);
  endfunction

  function automatic int wait_used(input int d);
    return case_passes(d) ? d - LB : T;
  endfunction

  task automatic run_sweep(input string tag, input bit spam);
    int lc[N];
    int nl, c, cur, ep, ef, eff, en;
    bit pb, pl;
    nl = 0; c = 0; cur = 0; pb = 1'b0; pl = 1'b0;
    for (int i = 0; i < N; i++) lc[i] = 0;
    @(negedge clk); start = 1'b1; valid = 1'b0;
    @(negedge clk); start = 1'b0;
    check({tag, ":busy_after_start"}, int'(busy), 1);
    check({tag, ":done_cleared"}, int'(done), 0);
    while (!done && c < 4000) begin
      if (load) begin
        if (nl == 0) check({tag, ":first_load_latency"}, c, ST);
        check({tag, ":load_addr"}, int'(addr), nl);
        check({tag, ":load_one_cycle"}, int'(pl), 0);
        cur = (nl < N) ? nl : N - 1;
        lc[cur] = c;
        nl++;
      end
      pl = load;
      valid = (nl > 0) && (dly[cur] > 0) && (c - lc[cur] == dly[cur]);
      start = spam && busy && ($urandom_range(0, 2) == 0);
      pb = busy;
      @(negedge clk); c++;
    end
    start = 1'b0; valid = 1'b0;
    check({tag, ":done_reached"}, int'(done), 1);
    check({tag, ":busy_low_at_done"}, int'(busy), 0);
    check({tag, ":busy_before_done"}, int'(pb), 1);

    ep = 0; ef = 0; eff = 0; en = 0;
    for (int a = 0; a < N; a++) begin
      en++;
      if (case_passes(dly[a])) ep++;
      else begin
        if (ef == 0) eff = a;
        ef++;
`ifdef PRESENT_SEQ_STOP_ON_FAIL_EN
        break;
`endif
      end
    end
    check({tag, ":cases_loaded"}, nl, en);
    check({tag, ":pass_cnt"}, int'(pass_cnt), ep);
    check({tag, ":fail_cnt"}, int'(fail_cnt), ef);
    check({tag, ":first_fail"}, int'(first_fail), eff);
    check({tag, ":all_pass"}, int'(all_pass), (ef == 0) ? 1 : 0);
    // Load-to-load spacing minus WAIT cycles used must be the same fixed
    // overhead for every case.
    for (int a = 1; a + 1 < nl && a + 1 < N; a++)
      check({tag, ":case_spacing"}, (lc[a+1] - lc[a]) - wait_used(dly[a]),
            (lc[1] - lc[0]) - wait_used(dly[0]));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("idle");

    for (int a = 0; a < N; a++) dly[a] = 35;
    run_sweep("all_pass", 1'b0);

    dly[5] = 0; dly[17] = 0;
    run_sweep("two_fail", 1'b0);
    run_sweep("two_fail_again_spam", 1'b1);

    for (int a = 0; a < N; a++) dly[a] = 35;
    dly[4] = 1; dly[9] = LB;
    run_sweep("blank_only", 1'b0);

    for (int a = 0; a < N; a++) dly[a] = 35;
    dly[3] = 0;
    run_sweep("fail_at_3", 1'b0);

    for (int a = 0; a < N; a++) begin
      dly[a] = int'($urandom_range(1, 46));
      if (dly[a] == 46) dly[a] = 0;
    end
    dly[0] = LB + T; dly[1] = LB + T + 1; dly[2] = LB + 1; dly[3] = LB;
    run_sweep("random_edges", 1'b1);

    // Reset while waiting on address 10, then a fresh sweep from address 0.
    for (int a = 0; a < N; a++) dly[a] = 35;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    begin
      int guard;
      guard = 0;
      while (!(load && addr == AW'(10)) && guard < 2000) begin
        @(negedge clk); guard++;
      end
      check("rst_mid:reached_addr10", guard < 2000 ? 1 : 0, 1);
    end
    repeat (LB + 3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("rst_mid");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("rst_mid_idle");
    run_sweep("after_reset", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
